router_input_port: RTL and testbench

- Input-port stage of the ring router. It sits directly downstream of a neighbour's output link, or of the PE's network interface (net_so/net_ro/net_do).
- Holds one single-slot buffer per virtual channel (VC0 = even, VC1 = odd). A packet is written into the VC equal to the current polarity and is offered to the router switch on the opposite polarity.
- Decodes the hop field and produces either a forward request or a local-eject request. On forward, the hop count is decremented.

---
 rtl/ring_pkg.sv | 16 +
 rtl/vc_slot.sv | 33 +++
 rtl/router_input_port.sv | 95 +++++++++
 tb/tb_router_input_port.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// Shared packet-format constants for the ring router.
package ring_pkg;

  localparam int PKT_W   = 64;
  localparam int VC_BIT  = 63;
  localparam int DIR_BIT = 62;
  localparam int HOP_MSB = 55;
  localparam int HOP_LSB = 48;
  localparam int SRC_MSB = 47;
  localparam int SRC_LSB = 32;
  localparam int HOP_W   = HOP_MSB - HOP_LSB + 1;

  localparam logic DIR_CW  = 1'b0;
  localparam logic DIR_CCW = 1'b1;

endpackage

// File: rtl/vc_slot.sv
// Single-entry virtual-channel buffer: one packet register plus its full flag.
module vc_slot
  import ring_pkg::*;
#(
  parameter int DW = PKT_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic          rd_clr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full
);

  logic [DW-1:0] data_p0;

  // Stage p0: slot storage. The parent never writes and clears one slot in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_p0 <= '0;
      full    <= 1'b0;
    end else if (wr_en) begin
      data_p0 <= din;
      full    <= 1'b1;
    end else if (rd_clr) begin
      full    <= 1'b0;
    end
  end

  assign dout = data_p0;

endmodule

// File: rtl/router_input_port.sv
// Ring-router input port: two polarity-interleaved VC slots, hop decode and drop accounting.
module router_input_port
  import ring_pkg::*;
#(
  parameter int DW      = ring_pkg::PKT_W,
  parameter int HOP_LSB = ring_pkg::HOP_LSB,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             polarity,
  input  logic             si,
  output logic             ri,
  input  logic [DW-1:0]    di,
  output logic             req_fwd,
  output logic             req_dir,
  output logic             req_local,
  input  logic             gnt,
  output logic [DW-1:0]    dout,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             err
);

  function automatic logic [HOP_W-1:0] hop_dec(input logic [HOP_W-1:0] h);
    return h - HOP_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  logic          wr_vc;
  logic          rd_vc;
  logic [1:0]    full;
  logic [1:0]    wr_en;
  logic [1:0]    rd_clr;
  logic [DW-1:0] slot_q [2];
  logic [DW-1:0] rd_pkt;
  logic [HOP_W-1:0] hop;
  logic          drop;

  // Write and read VCs are always opposite, so a slot is never written and drained together.
  assign wr_vc = polarity;
  assign rd_vc = ~polarity;
  assign ri    = ~full[wr_vc];
  assign drop  = si & full[wr_vc];

  for (genvar i = 0; i < 2; i++) begin : g_vc
    assign wr_en[i]  = si  && (wr_vc == 1'(i)) && !full[i];
    assign rd_clr[i] = gnt && (rd_vc == 1'(i)) &&  full[i];

    vc_slot #(.DW(DW)) u_slot (
      .clk    (clk),
      .reset  (reset),
      .wr_en  (wr_en[i]),
      .rd_clr (rd_clr[i]),
      .din    (di),
      .dout   (slot_q[i]),
      .full   (full[i])
    );
  end

  assign rd_pkt = slot_q[rd_vc];
  assign hop    = rd_pkt[HOP_LSB +: HOP_W];

  // Hop 0 always ejects, so decrementing a non-zero hop can never wrap.
  always_comb begin
    req_fwd   = 1'b0;
    req_local = 1'b0;
    req_dir   = DIR_CW;
    dout      = '0;
    if (full[rd_vc]) begin
      dout = rd_pkt;
      if (hop != '0) begin
        req_fwd                  = 1'b1;
        req_dir                  = rd_pkt[DIR_BIT];
        dout[HOP_LSB +: HOP_W]   = hop_dec(hop);
      end else begin
        req_local = 1'b1;
      end
    end
  end

  // Stage p0: protocol-violation accounting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt <= '0;
      err      <= 1'b0;
    end else if (drop) begin
      drop_cnt <= sat_inc(drop_cnt);
      err      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_router_input_port.sv
// Scoreboard bench for router_input_port: directed packets, per-VC expected queues, negedge monitor.
module tb_router_input_port;

  localparam int DW    = 64;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             polarity;
  logic             si;
  logic             ri;
  logic [DW-1:0]    di;
  logic             req_fwd;
  logic             req_dir;
  logic             req_local;
  logic             gnt;
  logic [DW-1:0]    dout;
  logic [CNT_W-1:0] drop_cnt;
  logic             err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic          fwd;
    logic          loc;
    logic          dir;
    logic [DW-1:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t mon_e;
  logic mon_rv;
  int   mon_qn;

  router_input_port #(.DW(DW), .HOP_LSB(48), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .polarity  (polarity),
    .si        (si),
    .ri        (ri),
    .di        (di),
    .req_fwd   (req_fwd),
    .req_dir   (req_dir),
    .req_local (req_local),
    .gnt       (gnt),
    .dout      (dout),
    .drop_cnt  (drop_cnt),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic push(input logic vc, input logic fwd, input logic dir, input logic [DW-1:0] d);
    exp_t e;
    e.fwd  = fwd;
    e.loc  = ~fwd;
    e.dir  = dir;
    e.data = d;
    if (vc) q1.push_back(e);
    else    q0.push_back(e);
  endtask

  // One cycle: inputs held until the edge, then polarity flips and inputs idle.
  task automatic cyc(input logic s, input logic [DW-1:0] d, input logic g);
    si  = s;
    di  = d;
    gnt = g;
    @(posedge clk);
    #1;
    polarity = ~polarity;
    si  = 1'b0;
    gnt = 1'b0;
    di  = '0;
    #1;
  endtask

  task automatic idle_to(input logic p);
    if (polarity !== p) cyc(1'b0, '0, 1'b0);
  endtask

  // Monitor: compares the offer on the read VC against that VC's expected queue.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      mon_rv = ~polarity;
      mon_qn = mon_rv ? q1.size() : q0.size();
      if (req_fwd || req_local || mon_qn != 0) begin
        checks++;
        if (mon_qn == 0) begin
          errors++;
          $display("FAIL unexpected_offer vc%0d: fwd=%b local=%b dout=%h", mon_rv, req_fwd, req_local, dout);
        end else begin
          mon_e = mon_rv ? q1[0] : q0[0];
          if (req_fwd !== mon_e.fwd || req_local !== mon_e.loc || dout !== mon_e.data ||
              (mon_e.fwd && req_dir !== mon_e.dir)) begin
            errors++;
            $display("FAIL offer_vc%0d: got fwd=%b local=%b dir=%b dout=%h expected fwd=%b local=%b dir=%b dout=%h",
                     mon_rv, req_fwd, req_local, req_dir, dout, mon_e.fwd, mon_e.loc, mon_e.dir, mon_e.data);
          end
          if (gnt) begin
            if (mon_rv) void'(q1.pop_front());
            else        void'(q0.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset    = 1'b0;
    polarity = 1'b0;
    si       = 1'b1;
    gnt      = 1'b1;
    di       = 64'hFFFF_FFFF_FFFF_FFFF;
    #12;
    chk("rst_ri", ri, 1);
    chk("rst_req_fwd", req_fwd, 0);
    chk("rst_req_local", req_local, 0);
    chk("rst_dout", dout, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_err", err, 0);
    @(posedge clk);
    #3;
    chk("rst_hold_dout", dout, 0);
    si    = 1'b0;
    gnt   = 1'b0;
    di    = '0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    polarity = 1'b0;
    #1;

    // Forward: hop 3 becomes 2
    chk("ri_after_reset", ri, 1);
    push(1'b0, 1'b1, 1'b0, 64'h0002_0000_0001_0005);
    cyc(1'b1, 64'h0003_0000_0001_0005, 1'b0);
    cyc(1'b0, '0, 1'b1);
    chk("ri_freed_vc0", ri, 1);
    cyc(1'b0, '0, 1'b0);
    chk("no_reoffer", req_fwd, 0);
    cyc(1'b0, '0, 1'b0);

    // Eject: hop 0 passes through unmodified
    idle_to(1'b1);
    push(1'b1, 1'b0, 1'b0, 64'h8000_0000_0002_00AA);
    cyc(1'b1, 64'h8000_0000_0002_00AA, 1'b0);
    cyc(1'b0, '0, 1'b1);

    // Backpressure with a dropped second write on VC0
    idle_to(1'b0);
    push(1'b0, 1'b1, 1'b1, 64'h4004_1234_5678_9ABC);
    cyc(1'b1, 64'h4005_1234_5678_9ABC, 1'b0);
    for (int i = 0; i < 6; i++) begin
      if (polarity == 1'b0) begin
        chk("ri_backpressure", ri, 0);
        if (i == 3) cyc(1'b1, 64'h0009_DEAD_BEEF_0000, 1'b0);
        else        cyc(1'b0, '0, 1'b0);
      end else begin
        chk("req_held", req_fwd, 1);
        cyc(1'b0, '0, 1'b0);
      end
    end
    chk("drop_cnt_one", drop_cnt, 1);
    chk("err_set", err, 1);
    cyc(1'b0, '0, 1'b1);

    // Concurrency: drain VC1 and fill VC0 on the same edge; hop FF forwards as FE
    idle_to(1'b1);
    push(1'b1, 1'b1, 1'b1, 64'hC000_0000_0003_0033);
    cyc(1'b1, 64'hC001_0000_0003_0033, 1'b0);
    push(1'b0, 1'b1, 1'b0, 64'h00FE_ABCD_0004_0044);
    cyc(1'b1, 64'h00FF_ABCD_0004_0044, 1'b1);
    chk("no_drop_concurrent", drop_cnt, 1);
    chk("ri_vc1_freed", ri, 1);
    cyc(1'b0, '0, 1'b1);
    chk("ri_vc0_freed", ri, 1);
    cyc(1'b0, '0, 1'b0);

    // Saturation: 260 more drops on a held VC0 packet
    idle_to(1'b0);
    push(1'b0, 1'b0, 1'b0, 64'h0000_0000_0000_0001);
    cyc(1'b1, 64'h0000_0000_0000_0001, 1'b0);
    n = 0;
    while (n < 260) begin
      if (polarity == 1'b0) begin
        cyc(1'b1, 64'h0000_0000_0000_0099, 1'b0);
        n++;
      end else begin
        cyc(1'b0, '0, 1'b0);
      end
    end
    chk("drop_cnt_sat", drop_cnt, 255);
    chk("err_sticky", err, 1);

    // Asynchronous reset between edges
    #1;
    reset = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    chk("async_drop_cnt", drop_cnt, 0);
    chk("async_err", err, 0);
    chk("async_ri", ri, 1);
    chk("async_req_local", req_local, 0);
    chk("async_dout", dout, 0);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    polarity = 1'b0;
    #1;
    push(1'b0, 1'b1, 1'b0, 64'h0000_0000_0000_0007);
    cyc(1'b1, 64'h0001_0000_0000_0007, 1'b0);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0);

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
